// File: rtl/gmii_udp_rx_demux.sv
// rtl/gmii_udp_rx_demux.sv - GMII Ethernet/IPv4/UDP receive parser splitting video and audio payloads into FIFO words.
// Header fields are captured by byte index; payload is unpacked into video or 12-bit audio words.
module gmii_udp_rx_demux #(
    parameter logic [31:0] IPV4_DST     = 32'hC0A80001,
    parameter logic [15:0] UDP_DST_PORT = 16'd12345,
    parameter int          PIX_BYTES    = 2,
    parameter int          ID_W         = 1,
    parameter logic [15:0] MAX_UDP_LEN  = 16'd1480,
    parameter logic [7:0]  TYPE_VIDEO   = 8'h00,
    parameter logic [7:0]  TYPE_AUDIO   = 8'h01
) (
    input  logic                       clk125,
    input  logic                       sys_rst,
    input  logic [ID_W-1:0]            id,
    input  logic [7:0]                 rxd,
    input  logic                       rx_dv,
    output logic [12+8*PIX_BYTES-1:0]  vid_data,
    output logic                       vid_wr_en,
    input  logic                       vid_full,
    output logic [11:0]                aux_data,
    output logic                       aux_wr_en,
    input  logic                       aux_full,
    output logic                       pkt_ok,
    output logic                       pkt_drop,
    output logic [15:0]                drop_cnt
);
    localparam int PW = 8 * PIX_BYTES;

    typedef enum logic [2:0] {IDLE, HDR, VIDEO, AUDIO, DROP} state_t;
    state_t state, state_next;

    logic [10:0]   cnt;
    logic          armed;
    logic [15:0]   ethertype, dst_port, udp_len;
    logic [7:0]    ver_ihl, protocol;
    logic [31:0]   dst_ip;
    logic [10:0]   y;
    logic          x_lsb;
    logic [PW-1:0] pix;
    logic [1:0]    pix_pos;
    logic [1:0]    aud_pos;
    logic [7:0]    aud_b0;
    logic [3:0]    aud_b1_hi;
    logic          vid_pend, aux_pend, ok_pend, drop_pend;

    logic          overflow, hdr_ok, at_hdr_end, at_end, active;
    logic [PW-1:0] pix_shift;
    logic [16:0]   end_idx;
    logic [31:0]   ip_expect;

    assign ip_expect  = {IPV4_DST[31:8], IPV4_DST[7:0] + 8'(id)};
    assign end_idx    = {1'b0, udp_len} + 17'd41;
    assign at_end     = ({6'd0, cnt} == end_idx);
    assign at_hdr_end = (state == HDR) && (cnt == 11'd50);
    assign hdr_ok     = (ethertype == 16'h0800) && (ver_ihl == 8'h45) && (protocol == 8'h11)
                     && (dst_ip == ip_expect) && (dst_port == UDP_DST_PORT)
                     && (udp_len >= 16'd11) && (udp_len <= MAX_UDP_LEN)
                     && ((rxd == TYPE_VIDEO) || (rxd == TYPE_AUDIO));
    // A pending write that meets a full FIFO aborts the frame in that same cycle.
    assign overflow   = (vid_pend && vid_full) || (aux_pend && aux_full);
    assign active     = (state == HDR) || (state == VIDEO) || (state == AUDIO);
    assign pix_shift  = PW'({pix, rxd});

    assign vid_wr_en  = vid_pend && !vid_full;
    assign aux_wr_en  = aux_pend && !aux_full;
    assign pkt_ok     = ok_pend && !overflow;
    assign pkt_drop   = drop_pend;

    always_ff @(posedge clk125 or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!rx_dv) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:  state_next = armed ? HDR : DROP;
                HDR: begin
                    if (cnt == 11'd50) begin
                        if (!hdr_ok)                 state_next = DROP;
                        else if (rxd == TYPE_VIDEO)  state_next = VIDEO;
                        else                         state_next = AUDIO;
                    end
                end
                VIDEO, AUDIO: begin
                    if (overflow || at_end) state_next = DROP;
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk125 or posedge sys_rst) begin
        if (sys_rst) begin
            cnt       <= '0;
            armed     <= 1'b0;
            ethertype <= '0;
            dst_port  <= '0;
            udp_len   <= '0;
            ver_ihl   <= '0;
            protocol  <= '0;
            dst_ip    <= '0;
            y         <= '0;
            x_lsb     <= 1'b0;
            pix       <= '0;
            pix_pos   <= '0;
            aud_pos   <= '0;
            aud_b0    <= '0;
            aud_b1_hi <= '0;
            vid_pend  <= 1'b0;
            aux_pend  <= 1'b0;
            ok_pend   <= 1'b0;
            drop_pend <= 1'b0;
            vid_data  <= '0;
            aux_data  <= '0;
            drop_cnt  <= '0;
        end else begin
            armed     <= armed || !rx_dv;
            vid_pend  <= 1'b0;
            aux_pend  <= 1'b0;
            ok_pend   <= rx_dv && ((state == VIDEO) || (state == AUDIO)) && at_end && !overflow;
            drop_pend <= overflow || (active && (!rx_dv || (at_hdr_end && !hdr_ok)));
            if (drop_pend && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

            if (!rx_dv) begin
                cnt       <= '0;
                ethertype <= '0;
                dst_port  <= '0;
                udp_len   <= '0;
                ver_ihl   <= '0;
                protocol  <= '0;
                dst_ip    <= '0;
                y         <= '0;
                x_lsb     <= 1'b0;
                pix       <= '0;
                pix_pos   <= '0;
                aud_pos   <= '0;
            end else begin
                if (cnt != 11'h7FF) cnt <= cnt + 11'd1;
                if (state == HDR) begin
                    case (cnt)
                        11'd20, 11'd21: ethertype <= {ethertype[7:0], rxd};
                        11'd22:         ver_ihl   <= rxd;
                        11'd31:         protocol  <= rxd;
                        11'd38, 11'd39,
                        11'd40, 11'd41: dst_ip    <= {dst_ip[23:0], rxd};
                        11'd44, 11'd45: dst_port  <= {dst_port[7:0], rxd};
                        11'd46, 11'd47: udp_len   <= {udp_len[7:0], rxd};
                        default: ;
                    endcase
                end
                if ((state == VIDEO) && !overflow) begin
                    if (cnt == 11'd51) begin
                        y[7:0] <= rxd;
                    end else if (cnt == 11'd52) begin
                        y[10:8] <= rxd[2:0];
                        x_lsb   <= rxd[4];
                    end else begin
                        pix <= pix_shift;
                        if (pix_pos == 2'(PIX_BYTES - 1)) begin
                            pix_pos  <= '0;
                            vid_pend <= 1'b1;
                            vid_data <= {x_lsb, y, pix_shift};
                        end else begin
                            pix_pos <= pix_pos + 2'd1;
                        end
                    end
                end
                if ((state == AUDIO) && !overflow) begin
                    case (aud_pos)
                        2'd0: begin
                            aud_b0  <= rxd;
                            aud_pos <= 2'd1;
                        end
                        2'd1: begin
                            aux_data  <= {rxd[3:0], aud_b0};
                            aux_pend  <= 1'b1;
                            aud_b1_hi <= rxd[7:4];
                            aud_pos   <= 2'd2;
                        end
                        default: begin
                            aux_data <= {rxd, aud_b1_hi};
                            aux_pend <= 1'b1;
                            aud_pos  <= 2'd0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_gmii_udp_rx_demux.sv
// tb/tb_gmii_udp_rx_demux.sv - directed and randomized frames checked against a byte-list reference model.
module tb_gmii_udp_rx_demux;
    localparam int P  = 2;
    localparam int PW = 8 * P;
    localparam int VW = 12 + PW;

    logic          clk125 = 1'b0;
    logic          sys_rst = 1'b1;
    logic [0:0]    id = 1'b0;
    logic [7:0]    rxd = 8'h00;
    logic          rx_dv = 1'b0;
    logic [VW-1:0] vid_data;
    logic          vid_wr_en;
    logic          vid_full = 1'b0;
    logic [11:0]   aux_data;
    logic          aux_wr_en;
    logic          aux_full = 1'b0;
    logic          pkt_ok, pkt_drop;
    logic [15:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    gmii_udp_rx_demux #(
        .IPV4_DST(32'hC0A80001), .UDP_DST_PORT(16'd12345), .PIX_BYTES(P), .ID_W(1),
        .MAX_UDP_LEN(16'd1480), .TYPE_VIDEO(8'h00), .TYPE_AUDIO(8'h01)
    ) dut (
        .clk125(clk125), .sys_rst(sys_rst), .id(id), .rxd(rxd), .rx_dv(rx_dv),
        .vid_data(vid_data), .vid_wr_en(vid_wr_en), .vid_full(vid_full),
        .aux_data(aux_data), .aux_wr_en(aux_wr_en), .aux_full(aux_full),
        .pkt_ok(pkt_ok), .pkt_drop(pkt_drop), .drop_cnt(drop_cnt)
    );

    always #4 clk125 = ~clk125;

    logic [7:0]    fr [0:2047];
    int            flen;
    bit            vf [0:2200];
    bit            af [0:2200];
    logic [VW-1:0] got_v [$];
    logic [11:0]   got_a [$];
    int            got_ok = 0;
    int            got_drop = 0;
    logic [VW-1:0] exp_v [$];
    logic [11:0]   exp_a [$];
    int            exp_ok, exp_drop;
    int            exp_cnt = 0;

    always @(negedge clk125) begin
        if (vid_wr_en) got_v.push_back(vid_data);
        if (aux_wr_en) got_a.push_back(aux_data);
        if (pkt_ok)    got_ok++;
        if (pkt_drop)  got_drop++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic build(input logic [31:0] dip, input logic [15:0] port, input logic [15:0] ulen,
                         input logic [7:0] typ, input logic [15:0] etype);
        int pl;
        for (int i = 0; i < 8; i++) fr[i] = (i == 7) ? 8'hD5 : 8'h55;
        for (int i = 8; i < 2048; i++) fr[i] = 8'($urandom);
        fr[20] = etype[15:8]; fr[21] = etype[7:0];
        fr[22] = 8'h45;       fr[31] = 8'h11;
        fr[38] = dip[31:24];  fr[39] = dip[23:16]; fr[40] = dip[15:8]; fr[41] = dip[7:0];
        fr[44] = port[15:8];  fr[45] = port[7:0];
        fr[46] = ulen[15:8];  fr[47] = ulen[7:0];
        fr[50] = typ;
        pl = (ulen >= 16'd9) ? int'(ulen) - 9 : 0;
        if (pl > 80) pl = 80;
        flen = 51 + pl + 4;
        if (flen < 72) flen = 72;
        for (int i = 0; i <= 2200; i++) begin
            vf[i] = 1'b0;
            af[i] = 1'b0;
        end
    endtask

    // Reference: header rules, E = udp_len + 41, word grouping and overflow by cycle index.
    task automatic model(input int len);
        logic [15:0] ulen;
        logic [10:0] y;
        logic        xl, good, ovf;
        logic [31:0] w;
        int          e, last;
        exp_v.delete(); exp_a.delete();
        exp_ok = 0; exp_drop = 0;
        if (len < 51) begin
            exp_drop = 1;
            return;
        end
        ulen = {fr[46], fr[47]};
        good = ({fr[20], fr[21]} == 16'h0800) && (fr[22] == 8'h45) && (fr[31] == 8'h11)
            && ({fr[38], fr[39], fr[40], fr[41]} == {24'hC0A800, 8'h01 + 8'(id)})
            && ({fr[44], fr[45]} == 16'd12345) && (ulen >= 16'd11) && (ulen <= 16'd1480)
            && ((fr[50] == 8'h00) || (fr[50] == 8'h01));
        if (!good) begin
            exp_drop = 1;
            return;
        end
        e    = int'(ulen) + 41;
        last = (e < len - 1) ? e : len - 1;
        ovf  = 1'b0;
        if (fr[50] == 8'h00) begin
            y  = {fr[52][2:0], fr[51]};
            xl = fr[52][4];
            for (int k = 0; 53 + k * P + P - 1 <= last; k++) begin
                if (vf[53 + k * P + P]) begin
                    ovf = 1'b1;
                    break;
                end
                w = 0;
                for (int j = 0; j < P; j++) w = (w << 8) | 32'(fr[53 + k * P + j]);
                exp_v.push_back({xl, y, w[PW-1:0]});
            end
        end else begin
            for (int n = 51; n <= last; n++) begin
                if (ovf) break;
                if ((n - 51) % 3 == 1) begin
                    if (af[n + 1]) ovf = 1'b1;
                    else exp_a.push_back({fr[n][3:0], fr[n - 1]});
                end else if ((n - 51) % 3 == 2) begin
                    if (af[n + 1]) ovf = 1'b1;
                    else exp_a.push_back({fr[n], fr[n - 1][7:4]});
                end
            end
        end
        if (ovf || (e > len - 1)) exp_drop = 1;
        else                      exp_ok = 1;
    endtask

    task automatic send();
        for (int i = 0; i < flen + 10; i++) begin
            @(posedge clk125); #1;
            rx_dv    = (i < flen);
            rxd      = (i < flen) ? fr[i] : 8'h00;
            vid_full = vf[i];
            aux_full = af[i];
        end
        @(posedge clk125); #1;
        vid_full = 1'b0;
        aux_full = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int b_ok, input int b_drop);
        chk({tag, "_vid_n"}, got_v.size(), exp_v.size());
        for (int i = 0; i < exp_v.size() && i < got_v.size(); i++) chk({tag, "_vid"}, 32'(got_v[i]), 32'(exp_v[i]));
        chk({tag, "_aux_n"}, got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) chk({tag, "_aux"}, 32'(got_a[i]), 32'(exp_a[i]));
        chk({tag, "_ok"}, got_ok - b_ok, exp_ok);
        chk({tag, "_drop"}, got_drop - b_drop, exp_drop);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), exp_cnt);
    endtask

    task automatic run_frame(input int len, input string tag);
        int b_ok, b_drop;
        model(len);
        if (exp_drop != 0 && exp_cnt != 16'hFFFF) exp_cnt++;
        got_v.delete(); got_a.delete();
        b_ok = got_ok; b_drop = got_drop;
        flen = len;
        send();
        check_frame(tag, b_ok, b_drop);
    endtask

    task automatic vid_plan_frame(input logic [31:0] dip);
        build(dip, 16'd12345, 16'd16, 8'h00, 16'h0800);
        fr[51] = 8'h23; fr[52] = 8'h11;
        fr[53] = 8'hAA; fr[54] = 8'hBB; fr[55] = 8'hCC; fr[56] = 8'hDD; fr[57] = 8'hEE;
    endtask

    initial begin
        int b_ok, b_drop;
        repeat (3) @(posedge clk125);
        @(negedge clk125);
        chk("rst_vid_wr_en", vid_wr_en, 0);
        chk("rst_aux_wr_en", aux_wr_en, 0);
        chk("rst_pkt_ok", pkt_ok, 0);
        chk("rst_pkt_drop", pkt_drop, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_aux_data", aux_data, 0);
        @(posedge clk125); #1 sys_rst = 1'b0;
        repeat (3) @(posedge clk125);

        id = 1'b0;
        vid_plan_frame(32'hC0A80001);
        run_frame(flen, "video");
        chk("video_w0_const", got_v[0], 28'h923AABB);
        chk("video_w1_const", got_v[1], 28'h923CCDD);

        id = 1'b1;
        vid_plan_frame(32'hC0A80001);
        run_frame(flen, "wrong_id");
        chk("wrong_id_cnt_const", drop_cnt, 16'd1);
        vid_plan_frame(32'hC0A80002);
        run_frame(flen, "id1_ok");

        id = 1'b0;
        build(32'hC0A80001, 16'd12345, 16'd14, 8'h01, 16'h0800);
        fr[51] = 8'h21; fr[52] = 8'h43; fr[53] = 8'h65; fr[54] = 8'h87; fr[55] = 8'h09;
        run_frame(flen, "audio");
        chk("audio_w0_const", got_a[0], 12'h321);
        chk("audio_w1_const", got_a[1], 12'h654);
        chk("audio_w2_const", got_a[2], 12'h987);

        vid_plan_frame(32'hC0A80001);
        vf[57] = 1'b1; vf[58] = 1'b1;
        run_frame(flen, "vid_full");

        build(32'hC0A80001, 16'd12345, 16'd100, 8'h00, 16'h0800);
        run_frame(55, "trunc");
        build(32'hC0A80001, 16'd12345, 16'd40, 8'h01, 16'h0800);
        run_frame(flen, "after_trunc");

        build(32'hC0A80001, 16'd12345, 16'd20, 8'h00, 16'h86DD);
        run_frame(flen, "bad_etype");
        build(32'hC0A80001, 16'd12345, 16'd8, 8'h00, 16'h0800);
        run_frame(flen, "len8");
        build(32'hC0A80001, 16'd12345, 16'd11, 8'h00, 16'h0800);
        run_frame(flen, "len11");
        build(32'hC0A80001, 16'd12345, 16'd20, 8'h00, 16'h0800);
        fr[31] = 8'h06;
        run_frame(flen, "bad_proto");
        build(32'hC0A80001, 16'd12345, 16'd20, 8'h05, 16'h0800);
        run_frame(flen, "bad_type");

        build(32'hC0A80001, 16'd12345, 16'd30, 8'h00, 16'h0800);
        got_v.delete(); got_a.delete();
        b_ok = got_ok; b_drop = got_drop;
        for (int i = 0; i < flen + 10; i++) begin
            @(posedge clk125); #1;
            rx_dv = (i < flen);
            rxd   = (i < flen) ? fr[i] : 8'h00;
            if (i == 30) #2 sys_rst = 1'b1;
            if (i == 32) sys_rst = 1'b0;
        end
        exp_v.delete(); exp_a.delete();
        exp_ok = 0; exp_drop = 0; exp_cnt = 0;
        check_frame("mid_reset", b_ok, b_drop);
        build(32'hC0A80001, 16'd12345, 16'd25, 8'h00, 16'h0800);
        run_frame(flen, "post_reset");

        @(negedge clk125);
        force dut.drop_cnt = 16'hFFFD;
        @(posedge clk125); #1;
        release dut.drop_cnt;
        exp_cnt = 16'hFFFD;
        for (int k = 0; k < 3; k++) begin
            build(32'hC0A80001, 16'd12345, 16'd8, 8'h00, 16'h0800);
            run_frame(flen, "sat");
        end
        chk("sat_const", drop_cnt, 16'hFFFF);

        for (int f = 0; f < 40; f++) begin
            logic [31:0] dip;
            logic [15:0] port, ulen;
            logic [7:0]  typ;
            int          r, len;
            id  = 1'($urandom_range(0, 1));
            dip = {24'hC0A800, 8'h01 + 8'(id)};
            if ($urandom_range(0, 7) == 0) dip[7:0] = dip[7:0] ^ 8'h03;
            port = ($urandom_range(0, 9) == 0) ? 16'd12346 : 16'd12345;
            r    = $urandom_range(0, 9);
            typ  = (r < 5) ? 8'h00 : (r < 9) ? 8'h01 : 8'h07;
            ulen = 16'($urandom_range(11, 60));
            if ($urandom_range(0, 9) == 0) ulen = ($urandom_range(0, 1) == 1) ? 16'd10 : 16'd1481;
            build(dip, port, ulen, typ, 16'h0800);
            if ($urandom_range(0, 4) == 0) vf[$urandom_range(52, flen)] = 1'b1;
            if ($urandom_range(0, 4) == 0) af[$urandom_range(52, flen)] = 1'b1;
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, flen - 1)) : flen;
            run_frame(len, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
